// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state type and NZVC flag positions for the sequential ALU.
package seq_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_INC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  localparam int unsigned FLAG_W = 4;
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_core.sv
// Combinational add/sub/logic datapath; subtraction is a + ~b + 1 so carry means "no borrow".
module seq_alu_core
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result_c,
  output logic [FLAG_W-1:0] flags_c
);

  logic             is_sub;
  logic             is_unit;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  // INC/DEC reuse the adder with a constant one in place of b
  always_comb begin
    is_unit = (op == OP_INC) || (op == OP_DEC);
    is_sub  = (op == OP_SUB) || (op == OP_DEC);
    opnd    = is_unit ? WIDTH'(1) : b;
    addend  = is_sub ? ~opnd : opnd;
    sum     = {1'b0, a} + {1'b0, addend} + (WIDTH+1)'(is_sub);
  end

  always_comb begin
    result_c = '0;
    flags_c  = '0;
    case (op)
      OP_ADD, OP_INC, OP_SUB, OP_DEC: begin
        result_c        = sum[WIDTH-1:0];
        flags_c[FLAG_C] = sum[WIDTH];
        flags_c[FLAG_V] = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      default: result_c = '0;
    endcase
    flags_c[FLAG_N] = result_c[WIDTH-1];
    flags_c[FLAG_Z] = (result_c == '0);
  end

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-bit ALU with valid/ready handshake and a WIDTH-cycle shift-add multiply.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [2:0]        Op,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [WIDTH-1:0]  Result,
  output logic [WIDTH-1:0]  Result_Hi,
  output logic [FLAG_W-1:0] NZVC
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t state;
  state_t state_d;

  logic               accept;
  logic [WIDTH-1:0]   core_result_c;
  logic [FLAG_W-1:0]  core_flags_c;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  // bit 0 of the product is shifted out before it is ever needed, so it is not stored
  logic [2*WIDTH-1:1] prod;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     mul_upper_c;
  logic [2*WIDTH-1:0] prod_next_c;
  logic [FLAG_W-1:0]  mul_flags_c;
  logic               mul_last;

  assign In_Ready = !Reset && ((state == ST_IDLE) || ((state == ST_HOLD) && Out_Ready));
  assign accept   = In_Valid && In_Ready;
  assign mul_last = (count == CW'(1));

  seq_alu_core #(.WIDTH(WIDTH)) u_core (
    .op       (Op),
    .a        (A),
    .b        (B),
    .result_c (core_result_c),
    .flags_c  (core_flags_c)
  );

  // One shift-add step: conditional add into the upper half, then shift right
  always_comb begin
    mul_upper_c = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    prod_next_c = {mul_upper_c, prod[WIDTH-1:1]};
    mul_flags_c = '0;
    mul_flags_c[FLAG_N] = prod_next_c[WIDTH-1];
    mul_flags_c[FLAG_Z] = (prod_next_c[WIDTH-1:0] == '0);
    mul_flags_c[FLAG_C] = (prod_next_c[2*WIDTH-1:WIDTH] != '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept) state_d = (Op == OP_MUL) ? ST_MUL : ST_HOLD;
      ST_MUL:  if (mul_last) state_d = ST_HOLD;
      ST_HOLD: begin
        if (accept)         state_d = (Op == OP_MUL) ? ST_MUL : ST_HOLD;
        else if (Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Out_Valid <= 1'b0;
      Result    <= '0;
      Result_Hi <= '0;
      NZVC      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      count     <= '0;
    end else begin
      Out_Valid <= (state_d == ST_HOLD);
      if (accept) begin
        if (Op == OP_MUL) begin
          mcand  <= A;
          mplier <= B;
          prod   <= '0;
          count  <= CW'(WIDTH);
        end else begin
          Result    <= core_result_c;
          Result_Hi <= '0;
          NZVC      <= core_flags_c;
        end
      end else if (state == ST_MUL) begin
        prod   <= prod_next_c[2*WIDTH-1:1];
        mplier <= mplier >> 1;
        count  <= count - CW'(1);
        if (mul_last) begin
          Result    <= prod_next_c[WIDTH-1:0];
          Result_Hi <= prod_next_c[2*WIDTH-1:WIDTH];
          NZVC      <= mul_flags_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       In_Valid;
  logic       In_Ready;
  logic [2:0] Op;
  logic [7:0] A;
  logic [7:0] B;
  logic       Out_Valid;
  logic       Out_Ready;
  logic [7:0] Result;
  logic [7:0] Result_Hi;
  logic [3:0] NZVC;

  int total = 0;
  int bad   = 0;

  seq_alu #(.WIDTH(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Op        (Op),
    .A         (A),
    .B         (B),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result),
    .Result_Hi (Result_Hi),
    .NZVC      (NZVC)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int to_signed8(input logic [7:0] v);
    return (v > 8'd127) ? int'(v) - 256 : int'(v);
  endfunction

  // Reference: plain integer arithmetic on the opcode's meaning
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] r, output logic [7:0] h, output logic [3:0] f);
    int s;
    int ss;
    int p;
    logic v;
    logic c;
    logic [7:0] bb;
    v = 1'b0; c = 1'b0; h = 8'h00; s = 0; ss = 0;
    bb = (op == OP_INC || op == OP_DEC) ? 8'h01 : b;
    case (op)
      OP_ADD, OP_INC: begin
        s  = int'(a) + int'(bb);
        ss = to_signed8(a) + to_signed8(bb);
        c  = (s > 255);
        v  = (ss > 127) || (ss < -128);
      end
      OP_SUB, OP_DEC: begin
        s  = int'(a) - int'(bb) + 256;
        ss = to_signed8(a) - to_signed8(bb);
        c  = (a >= bb);
        v  = (ss > 127) || (ss < -128);
      end
      OP_AND: s = int'(a & b);
      OP_OR:  s = int'(a | b);
      OP_XOR: s = int'(a ^ b);
      default: begin
        p = int'(a) * int'(b);
        s = p % 256;
        h = 8'(p / 256);
        c = (h != 8'h00);
      end
    endcase
    r = 8'(s % 256);
    f = {r[7], (r == 8'h00), v, c};
  endtask

  // Issue one op, wait for acceptance, then check latency and the held result
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eh, input logic [3:0] ef,
                        input string tag);
    int n;
    Op = op; A = a; B = b; In_Valid = 1'b1; Out_Ready = 1'b1;
    #1;
    n = 0;
    while (In_Ready !== 1'b1 && n < 50) begin
      @(negedge Clock); #1; n++;
    end
    check({tag, "_rdy"}, {31'd0, In_Ready}, 32'd1);
    @(posedge Clock);
    @(negedge Clock);
    In_Valid = 1'b0;
    #1;
    if (op == OP_MUL) begin
      for (int k = 0; k < 8; k++) begin
        check({tag, "_busy_rdy"}, {31'd0, In_Ready}, 32'd0);
        check({tag, "_busy_vld"}, {31'd0, Out_Valid}, 32'd0);
        @(negedge Clock); #1;
      end
    end
    check({tag, "_vld"}, {31'd0, Out_Valid}, 32'd1);
    check({tag, "_res"}, {24'd0, Result}, {24'd0, er});
    check({tag, "_hi"},  {24'd0, Result_Hi}, {24'd0, eh});
    check({tag, "_nzvc"}, {28'd0, NZVC}, {28'd0, ef});
  endtask

  initial begin
    logic [7:0] mr;
    logic [7:0] mh;
    logic [3:0] mf;
    logic [2:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;

    Reset = 1'b1; In_Valid = 1'b0; Out_Ready = 1'b0;
    Op = OP_ADD; A = 8'h00; B = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); @(negedge Clock); #1;
      check("rst_rdy",  {31'd0, In_Ready}, 32'd0);
      check("rst_vld",  {31'd0, Out_Valid}, 32'd0);
      check("rst_res",  {24'd0, Result}, 32'd0);
      check("rst_nzvc", {28'd0, NZVC}, 32'd0);
    end
    Reset = 1'b0;
    #1;
    check("rel_rdy", {31'd0, In_Ready}, 32'd1);

    run_op(OP_ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1010, "add_ovf");
    run_op(OP_ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0101, "add_wrap");
    run_op(OP_DEC, 8'h00, 8'h5A, 8'hFF, 8'h00, 4'b1000, "dec_zero");
    run_op(OP_INC, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0101, "inc_ones");
    run_op(OP_SUB, 8'h05, 8'h07, 8'hFE, 8'h00, 4'b1000, "sub_borrow");
    run_op(OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0011, "sub_ovf");
    run_op(OP_MUL, 8'h10, 8'h20, 8'h00, 8'h02, 4'b0101, "mul_dir");
    run_op(OP_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0001, "mul_max");

    // Back-to-back logic ops with the consumer always ready
    @(negedge Clock); #1;
    Op = OP_AND; A = 8'hF0; B = 8'h3C; In_Valid = 1'b1; Out_Ready = 1'b1;
    @(posedge Clock); @(negedge Clock); #1;
    check("b2b_and_vld", {31'd0, Out_Valid}, 32'd1);
    check("b2b_and", {24'd0, Result}, 32'h30);
    check("b2b_and_rdy", {31'd0, In_Ready}, 32'd1);
    Op = OP_OR;
    @(posedge Clock); @(negedge Clock); #1;
    check("b2b_or", {24'd0, Result}, 32'hFC);
    check("b2b_or_rdy", {31'd0, In_Ready}, 32'd1);
    Op = OP_XOR;
    @(posedge Clock); @(negedge Clock); #1;
    check("b2b_xor", {24'd0, Result}, 32'hCC);
    check("b2b_xor_nzvc", {28'd0, NZVC}, 32'b1000);

    // Consumer stalls: result must be held and input blocked
    Op = OP_ADD; Out_Ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_rdy", {31'd0, In_Ready}, 32'd0);
      @(posedge Clock); @(negedge Clock); #1;
      check("stall_res", {24'd0, Result}, 32'hCC);
      check("stall_vld", {31'd0, Out_Valid}, 32'd1);
    end
    Out_Ready = 1'b1;
    @(posedge Clock); @(negedge Clock); #1;
    In_Valid = 1'b0;
    check("stall_add", {24'd0, Result}, 32'h2C);
    check("stall_add_nzvc", {28'd0, NZVC}, 32'b0001);

    // Reset lands on the 4th multiply iteration
    @(negedge Clock); #1;
    Op = OP_MUL; A = 8'h10; B = 8'h20; In_Valid = 1'b1;
    #1;
    check("mrst_rdy", {31'd0, In_Ready}, 32'd1);
    @(posedge Clock); @(negedge Clock); #1;
    In_Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); @(negedge Clock); #1;
    end
    Reset = 1'b1;
    @(posedge Clock); @(negedge Clock); #1;
    check("mrst_vld", {31'd0, Out_Valid}, 32'd0);
    check("mrst_res", {24'd0, Result}, 32'd0);
    check("mrst_hi",  {24'd0, Result_Hi}, 32'd0);
    check("mrst_nzvc", {28'd0, NZVC}, 32'd0);
    check("mrst_rdy0", {31'd0, In_Ready}, 32'd0);
    Reset = 1'b0;
    #1;
    check("mrst_idle_rdy", {31'd0, In_Ready}, 32'd1);
    run_op(OP_ADD, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, "post_rst_add");

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (i % 10 == 0) ra = 8'h00;
      if (i % 10 == 5) rb = 8'hFF;
      model(rop, ra, rb, mr, mh, mf);
      run_op(rop, ra, rb, mr, mh, mf, $sformatf("rnd%0d_op%0d", i, rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the 8-bit arithmetic/logic units: one WIDTH-bit ALU with arithmetic, logic and a multi-cycle shift-add multiply behind a valid/ready handshake. Result and NZVC flags are registered and held until consumed. It sits between operand sourcing (register file / sequencer) and writeback, and replaces direct instantiation of the combinational arithmetic and logic units.

## Interface
- WIDTH, 8, operand/result width; legal range WIDTH ≥ 2.
- Clock  in  1  single clock; every register updates on its rising edge.
- Reset  in  1  synchronous, active-high.
- In_Valid  in  1  operand/op presented.
- In_Ready  out  1  block accepts the current operands this cycle.
- Op  in  3  opcode: 000 ADD, 001 INC, 010 SUB, 011 DEC, 100 AND, 101 OR, 110 XOR, 111 MUL.
- A, B  in  WIDTH  operands (INC/DEC ignore B).
- Out_Valid  out  1  Result/Result_Hi/NZVC valid.
- Out_Ready  in  1  consumer takes the result.
- Result  out  WIDTH  result; for MUL, the low half of the product.
- Result_Hi  out  WIDTH  upper half of the MUL product; 0 for other ops.
- NZVC  out  4  {N,Z,V,C} for Result.

## Operation
- FSM states: IDLE, MUL, HOLD. Reset → IDLE.
- Accept = In_Valid & In_Ready, where In_Ready = !Reset & (IDLE | (HOLD & Out_Ready)). Op/A/B are sampled only on the accept edge.
- Single-cycle op accepted: Result/NZVC are written on the accept edge and the FSM enters HOLD.
- MUL accepted: on the accept edge, load multiplicand, multiplier, zeroed 2·WIDTH product and count = WIDTH, then enter MUL. Each MUL edge: if multiplier LSB is 1, add the multiplicand into the product's upper half with carry; shift right; decrement count. The edge that takes count to 0 writes Result/Result_Hi/NZVC and enters HOLD.
- HOLD: Out_Valid = 1; outputs stay stable until Out_Ready. With Out_Ready = 1:
  - new accept that cycle → handled as from IDLE;
  - no accept → IDLE, Out_Valid drops.
- Flags:
  - N = Result[WIDTH-1]; Z = (Result == 0).
  - ADD/INC: C = adder carry-out; V = signed overflow.
  - SUB/DEC: computed as A + ~B + 1; C = 1 when there is no borrow (A ≥ B unsigned); V = signed overflow.
  - Logic ops: V = C = 0.
  - MUL: V = 0; C = (Result_Hi ≠ 0).
- Wrap-around is modulo 2^WIDTH: INC of all-ones → 0 with C=1; DEC of 0 → all-ones with C=0.

## Timing
- Reset high at an edge: FSM → IDLE; Out_Valid, Result, Result_Hi and NZVC → 0; the MUL counter is cleared. Reset overrides any in-flight MUL or HOLD.
- In_Ready is 0 while Reset is high.
- Latency (accept edge to first cycle with Out_Valid = 1):
  - single-cycle ops: the cycle after the accept edge;
  - MUL: the cycle after the WIDTH-th edge following the accept edge.
- Throughput: one single-cycle op per clock while Out_Ready = 1; MUL blocks input for WIDTH cycles (In_Ready = 0 in MUL).
- Out_Valid never drops without a handshake except on Reset.

## Structure
- Package seq_alu_pkg: opcode localparams, the FSM state enum, flag bit indices (N=3, Z=2, V=1, C=0).
- Sub-module seq_alu_core: combinational WIDTH-bit add/sub/logic datapath producing result and NZVC. The top level holds the FSM, operand/product registers and the MUL counter, which is $clog2(WIDTH+1) bits wide.

## Test plan
All scenarios use WIDTH=8.
- Reset held 2 cycles, then released → during reset In_Ready=0, Out_Valid=0, Result=0x00, NZVC=0000; In_Ready=1 the first cycle after release.
- ADD 0x7F+0x01 → Result 0x80, NZVC 1010. ADD 0xFF+0x01 → 0x00, NZVC 0101. DEC 0x00 → 0xFF, NZVC 1000. Each has Out_Valid on the cycle after accept.
- SUB 0x05−0x07 → 0xFE, NZVC 1000. SUB 0x80−0x01 → 0x7F, NZVC 0011.
- MUL 0x10×0x20 → Result 0x00, Result_Hi 0x02, NZVC 0101. Out_Valid rises in the cycle after the 8th edge following accept; In_Ready=0 throughout MUL.
- AND, OR, XOR of 0xF0 and 0x3C issued back-to-back with Out_Ready=1 → 0x30, 0xFC, 0xCC on consecutive cycles. Repeat with Out_Ready=0 for 3 cycles → Result held stable, In_Ready=0.
- Reset asserted at the 4th MUL iteration → next cycle: IDLE, Out_Valid=0, all outputs 0; a following ADD 0x01+0x01 returns 0x02, NZVC 0000.
